// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared constants and state encoding for adder_share_ctrl
package adder_share_pkg;

    localparam int ADD_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round-robin pick between two requesters; caller guarantees |req.
    // With both requesting, the one that did not win last time goes next.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11) begin
            return ~last_grant;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/fa16.sv
// rtl/fa16.sv - 16-bit ripple-carry full adder datapath
// Ports: A, B (addends), Ci (carry in), S (sum), Co (carry out). Purely combinational.
module FA16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Ci,
    output logic [15:0] S,
    output logic        Co
);

    logic [16:0] c;

    assign c[0] = Ci;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_bit
            assign S[i]   = A[i] ^ B[i] ^ c[i];
            assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Co = c[16];

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - time-shares one FA16 between two add/subtract requesters
// Ports: clk, rst_n (async active-low); req/op/A0/B0/A1/B1 from requesters;
//        gnt/done one-hot pulses; S/Co/V/Z registered result and flags; busy.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic [W-1:0]    A0,
    input  logic [W-1:0]    B0,
    input  logic [W-1:0]    A1,
    input  logic [W-1:0]    B1,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [W-1:0]    S,
    output logic            Co,
    output logic            V,
    output logic            Z,
    output logic            busy
);

    state_t         state, state_nxt;
    logic [W-1:0]   op_a, op_b;
    logic           op_sub;
    logic           owner;
    logic           last_grant;

    logic           grant_owner;
    logic           grant_take;
    logic [NREQ-1:0] gnt_c;

    logic [W-1:0]   b_mod;
    logic [W-1:0]   sum;
    logic           carry;

    always_comb begin
        state_nxt   = state;
        grant_take  = 1'b0;
        grant_owner = 1'b0;
        gnt_c       = '0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_take  = 1'b1;
                    grant_owner = rr_pick(req, last_grant);
                    gnt_c       = grant_owner ? 2'b10 : 2'b01;
                    state_nxt   = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Subtract is A + ~B + 1, so the op bit doubles as the carry-in.
    assign b_mod = (op_sub == OP_SUB) ? ~op_b : op_b;

    FA16 u_fa16 (
        .A  (op_a),
        .B  (b_mod),
        .Ci (op_sub),
        .S  (sum),
        .Co (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= OP_ADD;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            S          <= '0;
            Co         <= 1'b0;
            V          <= 1'b0;
            Z          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_take) begin
                op_a       <= grant_owner ? A1 : A0;
                op_b       <= grant_owner ? B1 : B0;
                op_sub     <= op[grant_owner];
                owner      <= grant_owner;
                last_grant <= grant_owner;
            end
            if (state == ST_EXEC) begin
                S  <= sum;
                Co <= carry;
                V  <= (op_a[W-1] == b_mod[W-1]) && (sum[W-1] != op_a[W-1]);
                Z  <= (sum == '0);
            end
        end
    end

    // gnt is decoded from IDLE and live req, so it is masked while reset is
    // asserted to keep it low even if requesters hold req through reset.
    assign gnt  = gnt_c & {NREQ{rst_n}};
    assign done = (state == ST_DONE) ? (owner ? 2'b10 : 2'b01) : '0;
    assign busy = (state == ST_EXEC) || (state == ST_DONE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [15:0] A0, B0, A1, B1;
    logic [1:0]  gnt, done;
    logic [15:0] S;
    logic        Co, V, Z, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_share_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .op   (op),
        .A0   (A0),
        .B0   (B0),
        .A1   (A1),
        .B1   (B1),
        .gnt  (gnt),
        .done (done),
        .S    (S),
        .Co   (Co),
        .V    (V),
        .Z    (Z),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on integers. Returns {Co, V, Z, S}.
    function automatic logic [18:0] model(input logic o, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r;
        logic [15:0] s;
        logic co, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (o) begin
            s  = 16'((ua - ub) & 32'hFFFF);
            co = (ua >= ub);
            r  = sa - sb;
        end else begin
            s  = 16'((ua + ub) & 32'hFFFF);
            co = (ua + ub) > 65535;
            r  = sa + sb;
        end
        v = (r > 32767) || (r < -32768);
        return {co, v, (s == 16'h0), s};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_opnd(input logic who, input logic [15:0] a, input logic [15:0] b);
        if (who) begin
            A1 = a;
            B1 = b;
        end else begin
            A0 = a;
            B0 = b;
        end
    endtask

    task automatic run_single(input logic who, input logic o, input logic [15:0] a, input logic [15:0] b);
        logic [18:0] e;
        logic [1:0]  oh;
        int n;
        oh = who ? 2'b10 : 2'b01;
        set_opnd(who, a, b);
        op[who]  = o;
        req[who] = 1'b1;
        #1;
        n = 0;
        while (gnt !== oh && n < 12) begin
            step();
            n++;
        end
        chk("gnt", {30'd0, gnt}, {30'd0, oh});
        e = model(o, a, b);
        step();
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_done", {30'd0, done}, 32'd0);
        // Changing operands after capture must not disturb the result.
        set_opnd(who, 16'($urandom), 16'($urandom));
        step();
        chk("done", {30'd0, done}, {30'd0, oh});
        chk("S", {16'd0, S}, {16'd0, e[15:0]});
        chk("CoVZ", {29'd0, Co, V, Z}, {29'd0, e[18:16]});
        req[who] = 1'b0;
        step();
        chk("idle_done", {30'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [18:0] e;
        logic [1:0]  oh;
        logic        who;
        int n, last_cyc;

        rst_n = 1'b0;
        req = 2'b00;
        op = 2'b00;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        repeat (3) step();
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_S", {16'd0, S}, 32'd0);
        chk("rst_CoVZ", {29'd0, Co, V, Z}, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed cases.
        run_single(1'b0, 1'b0, 16'd5, 16'd40);
        chk("add5_40", {16'd0, S}, 32'd45);
        run_single(1'b1, 1'b1, 16'd3, 16'd5);
        chk("sub3_5", {16'd0, S, Co}, {15'd0, 16'hFFFE, 1'b0});
        run_single(1'b1, 1'b1, 16'd5, 16'd3);
        chk("sub5_3", {16'd0, S, Co}, {15'd0, 16'd2, 1'b1});
        run_single(1'b0, 1'b0, 16'd1, 16'hFFFF);
        chk("wrap_zero", {29'd0, Co, V, Z}, {29'd0, 3'b101});
        run_single(1'b0, 1'b0, 16'h7FFF, 16'd1);
        chk("ovf", {15'd0, S, V}, {15'd0, 16'h8000, 1'b1});

        // Random single-requester operations.
        for (int i = 0; i < 16; i++) begin
            run_single(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        end

        // Requester 0 granted, then reset lands in EXEC.
        run_single(1'b0, 1'b0, 16'h1234, 16'h1111);
        set_opnd(1'b0, 16'h0100, 16'h0001);
        req = 2'b01;
        #1;
        n = 0;
        while (gnt !== 2'b01 && n < 12) begin
            step();
            n++;
        end
        chk("mid_gnt", {30'd0, gnt}, 32'd1);
        step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        req = 2'b11;
        op = 2'b10;
        #1;
        chk("mid_rst_S", {16'd0, S}, 32'd0);
        chk("mid_rst_CoVZ", {29'd0, Co, V, Z}, 32'd0);
        chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("mid_rst_done", {30'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        chk("mid_rst_nodone", {30'd0, done}, 32'd0);
        chk("mid_rst_gnt2", {30'd0, gnt}, 32'd0);

        // Release with both requesting continuously: grants alternate from 0.
        set_opnd(1'b0, 16'd35, 16'($urandom));
        set_opnd(1'b1, 16'($urandom), 16'($urandom));
        rst_n = 1'b1;
        #1;
        last_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (gnt === 2'b00 && n < 12) begin
                step();
                n++;
            end
            who = 1'(k % 2);
            oh  = who ? 2'b10 : 2'b01;
            chk("rr_gnt", {30'd0, gnt}, {30'd0, oh});
            if (k > 0) chk("rr_spacing", cyc - last_cyc, 32'd3);
            last_cyc = cyc;
            e = who ? model(1'b1, A1, B1) : model(1'b0, A0, B0);
            step();
            step();
            chk("rr_done", {30'd0, done}, {30'd0, oh});
            chk("rr_S", {16'd0, S}, {16'd0, e[15:0]});
            chk("rr_CoVZ", {29'd0, Co, V, Z}, {29'd0, e[18:16]});
            set_opnd(who, who ? 16'($urandom) : 16'(k + 36), 16'($urandom));
            step();
        end
        req = 2'b00;
        repeat (4) step();
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
